// File: rtl/uparc_memory_access.sv
// uparc_memory_access
// Memory access stage of the Ultiparc pipeline. It issues at most one data
// bus transaction at a time and stalls the core while that transaction is in
// flight. It aligns and extends load data, detects misaligned accesses, and
// otherwise passes the ALU result through to writeback.
module uparc_memory_access (
  input  logic        clk,
  input  logic        nrst,
  // stalls from other units and pipeline kill
  input  logic        i_exec_stall,
  input  logic        i_fetch_stall,
  input  logic        i_wait_stall,
  input  logic        i_nullify,
  output logic        o_mem_stall,
  output logic        o_addr_error,
  output logic        o_bus_error,
  // from execute
  input  logic [4:0]  i_rd_no,
  input  logic [31:0] i_alu_result,
  input  logic [1:0]  i_lsu_op,
  input  logic        i_lsu_lns,
  input  logic        i_lsu_ext,
  input  logic [31:0] i_mem_data,
  // to writeback
  output logic [4:0]  o_rd_no,
  output logic [31:0] o_rd_val,
  // data bus
  output logic [31:0] o_dbus_addr,
  output logic [1:0]  o_dbus_cmd,
  output logic [3:0]  o_dbus_ben,
  output logic [31:0] o_dbus_wdata,
  input  logic [31:0] i_dbus_rdata,
  input  logic        i_dbus_rdy,
  input  logic        i_dbus_err
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam logic [1:0] OP_NONE   = 2'b00;
  localparam logic [1:0] OP_BYTE   = 2'b01;
  localparam logic [1:0] OP_HALF   = 2'b10;
  localparam logic [1:0] OP_WORD   = 2'b11;

  localparam logic [1:0] CMD_NONE  = 2'b00;
  localparam logic [1:0] CMD_READ  = 2'b01;
  localparam logic [1:0] CMD_WRITE = 2'b10;

  // A halfword must sit on an even address, a word on a 4-byte boundary.
  function automatic logic misaligned_f(input logic [1:0] op, input logic [1:0] a);
    logic r;
    case (op)
      OP_HALF: r = a[0];
      OP_WORD: r = (a != 2'b00);
      default: r = 1'b0;
    endcase
    return r;
  endfunction

  // Byte lanes touched by the access; little-endian, lane = addr[1:0].
  function automatic logic [3:0] ben_f(input logic [1:0] op, input logic [1:0] a);
    logic [3:0] r;
    case (op)
      OP_BYTE: r = 4'b0001 << a;
      OP_HALF: r = 4'b0011 << a;
      OP_WORD: r = 4'b1111;
      default: r = 4'b0000;
    endcase
    return r;
  endfunction

  // Store data replicated across all lanes so the enabled lanes carry it.
  function automatic logic [31:0] wdata_f(input logic [1:0] op, input logic [31:0] rt);
    logic [31:0] r;
    case (op)
      OP_BYTE: r = {4{rt[7:0]}};
      OP_HALF: r = {2{rt[15:0]}};
      OP_WORD: r = rt;
      default: r = 32'h0000_0000;
    endcase
    return r;
  endfunction

  // Shift the addressed lane down to bit 0, truncate, then sign/zero extend.
  function automatic logic [31:0] load_f(input logic [1:0] op, input logic ext,
                                         input logic [1:0] off, input logic [31:0] rdata);
    logic [31:0] sh;
    logic [31:0] r;
    sh = rdata >> {off, 3'b000};
    case (op)
      OP_BYTE: r = {{24{ext & sh[7]}}, sh[7:0]};
      OP_HALF: r = {{16{ext & sh[15]}}, sh[15:0]};
      OP_WORD: r = sh;
      default: r = 32'h0000_0000;
    endcase
    return r;
  endfunction

  // state and captured request
  state_t      state_q,   state_d;
  logic [1:0]  cmd_q,     cmd_d;
  logic [29:0] addr_q,    addr_d;
  logic [3:0]  ben_q,     ben_d;
  logic [31:0] wdata_q,   wdata_d;
  logic [4:0]  rd_cap_q,  rd_cap_d;
  logic [1:0]  op_q,      op_d;
  logic        ext_q,     ext_d;
  logic [1:0]  off_q,     off_d;
  // writeback outputs
  logic [4:0]  rd_no_q,   rd_no_d;
  logic [31:0] rd_val_q,  rd_val_d;
  logic        bus_err_q, bus_err_d;

  logic ostall_s;
  logic mem_op_s;
  logic misalign_s;
  logic issue_s;

  assign ostall_s   = i_exec_stall | i_fetch_stall | i_wait_stall;
  assign mem_op_s   = (i_lsu_op != OP_NONE) & ~i_nullify;
  assign misalign_s = misaligned_f(i_lsu_op, i_alu_result[1:0]);
  assign issue_s    = (state_q == ST_IDLE) & mem_op_s & ~misalign_s;

  assign o_mem_stall  = issue_s | ((state_q == ST_REQ) & ~i_dbus_rdy);
  assign o_addr_error = (state_q == ST_IDLE) & mem_op_s & misalign_s;

  assign o_bus_error  = bus_err_q;
  assign o_rd_no      = rd_no_q;
  assign o_rd_val     = rd_val_q;
  assign o_dbus_cmd   = cmd_q;
  assign o_dbus_addr  = {addr_q, 2'b00};
  assign o_dbus_ben   = ben_q;
  assign o_dbus_wdata = wdata_q;

  // Next-state, request capture and writeback update for the bus FSM.
  always_comb begin
    state_d   = state_q;
    cmd_d     = cmd_q;
    addr_d    = addr_q;
    ben_d     = ben_q;
    wdata_d   = wdata_q;
    rd_cap_d  = rd_cap_q;
    op_d      = op_q;
    ext_d     = ext_q;
    off_d     = off_q;
    rd_no_d   = rd_no_q;
    rd_val_d  = rd_val_q;
    bus_err_d = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (!ostall_s) begin
          if (mem_op_s && !misalign_s) begin
            // launch the transfer and send a bubble down the pipe
            state_d  = ST_REQ;
            cmd_d    = i_lsu_lns ? CMD_WRITE : CMD_READ;
            addr_d   = i_alu_result[31:2];
            ben_d    = ben_f(i_lsu_op, i_alu_result[1:0]);
            wdata_d  = wdata_f(i_lsu_op, i_mem_data);
            rd_cap_d = i_rd_no;
            op_d     = i_lsu_op;
            ext_d    = i_lsu_ext;
            off_d    = i_alu_result[1:0];
            rd_no_d  = 5'd0;
          end else if (mem_op_s) begin
            // misaligned: no bus cycle, no register write
            rd_no_d = 5'd0;
          end else begin
            rd_no_d  = i_nullify ? 5'd0 : i_rd_no;
            rd_val_d = i_alu_result;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end

      ST_REQ: begin
        if (i_dbus_rdy) begin
          // completion: the result is captured now because rdata is only
          // valid with rdy; DONE then holds it while the core is stalled
          cmd_d   = CMD_NONE;
          state_d = ostall_s ? ST_DONE : ST_IDLE;
          if (i_dbus_err) begin
            rd_no_d   = 5'd0;
            bus_err_d = 1'b1;
          end else if (i_nullify) begin
            rd_no_d = 5'd0;
          end else if (cmd_q == CMD_READ) begin
            rd_no_d  = rd_cap_q;
            rd_val_d = load_f(op_q, ext_q, off_q, i_dbus_rdata);
          end else begin
            rd_no_d = 5'd0;
          end
        end else begin
          state_d = ST_REQ;
        end
      end

      ST_DONE: begin
        // the finished instruction is still at the inputs; wait for it to leave
        if (!ostall_s) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_DONE;
        end
      end

      default: begin
        state_d = ST_IDLE;
        cmd_d   = CMD_NONE;
      end
    endcase
  end

  // State, request and writeback registers; reset drops any pending command.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q   <= ST_IDLE;
      cmd_q     <= CMD_NONE;
      addr_q    <= 30'd0;
      ben_q     <= 4'b0000;
      wdata_q   <= 32'h0000_0000;
      rd_cap_q  <= 5'd0;
      op_q      <= OP_NONE;
      ext_q     <= 1'b0;
      off_q     <= 2'b00;
      rd_no_q   <= 5'd0;
      rd_val_q  <= 32'h0000_0000;
      bus_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cmd_q     <= cmd_d;
      addr_q    <= addr_d;
      ben_q     <= ben_d;
      wdata_q   <= wdata_d;
      rd_cap_q  <= rd_cap_d;
      op_q      <= op_d;
      ext_q     <= ext_d;
      off_q     <= off_d;
      rd_no_q   <= rd_no_d;
      rd_val_q  <= rd_val_d;
      bus_err_q <= bus_err_d;
    end
  end

endmodule

// File: tb/tb_uparc_memory_access.sv
// Self-checking bench for uparc_memory_access. Expected writeback results
// are queued when an instruction is presented and popped when it retires.
module tb_uparc_memory_access;

  logic        clk;
  logic        nrst;
  logic        i_exec_stall, i_fetch_stall, i_wait_stall, i_nullify;
  logic        o_mem_stall, o_addr_error, o_bus_error;
  logic [4:0]  i_rd_no;
  logic [31:0] i_alu_result;
  logic [1:0]  i_lsu_op;
  logic        i_lsu_lns, i_lsu_ext;
  logic [31:0] i_mem_data;
  logic [4:0]  o_rd_no;
  logic [31:0] o_rd_val;
  logic [31:0] o_dbus_addr;
  logic [1:0]  o_dbus_cmd;
  logic [3:0]  o_dbus_ben;
  logic [31:0] o_dbus_wdata;
  logic [31:0] i_dbus_rdata;
  logic        i_dbus_rdy, i_dbus_err;

  typedef struct packed {
    logic [4:0]  rd;
    logic [31:0] val;
  } exp_t;

  exp_t sb_q[$];
  int checks = 0;
  int failures = 0;

  uparc_memory_access dut (
    .clk(clk), .nrst(nrst),
    .i_exec_stall(i_exec_stall), .i_fetch_stall(i_fetch_stall), .i_wait_stall(i_wait_stall),
    .i_nullify(i_nullify), .o_mem_stall(o_mem_stall), .o_addr_error(o_addr_error),
    .o_bus_error(o_bus_error), .i_rd_no(i_rd_no), .i_alu_result(i_alu_result),
    .i_lsu_op(i_lsu_op), .i_lsu_lns(i_lsu_lns), .i_lsu_ext(i_lsu_ext), .i_mem_data(i_mem_data),
    .o_rd_no(o_rd_no), .o_rd_val(o_rd_val), .o_dbus_addr(o_dbus_addr), .o_dbus_cmd(o_dbus_cmd),
    .o_dbus_ben(o_dbus_ben), .o_dbus_wdata(o_dbus_wdata), .i_dbus_rdata(i_dbus_rdata),
    .i_dbus_rdy(i_dbus_rdy), .i_dbus_err(i_dbus_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  // Drives one memory op already set up on the inputs; acts as bus slave.
  // Starts and ends one time unit after a rising edge.
  task automatic run_mem(input logic [31:0] rdata, input int wait_n, input logic err,
                         input logic hold_stall, output int stall_cnt,
                         output logic [1:0] cmd_s, output logic [31:0] addr_s,
                         output logic [3:0] ben_s, output logic [31:0] wdata_s,
                         output int req_cnt);
    logic [1:0] prev_cmd;
    int req_n;
    int cyc;
    bit done;
    prev_cmd = 2'b00; req_n = 0; cyc = 0; done = 0;
    stall_cnt = 0; req_cnt = 0;
    cmd_s = 2'b00; addr_s = 32'h0; ben_s = 4'h0; wdata_s = 32'h0;
    while (!done && cyc < 40) begin
      @(negedge clk);
      if (o_dbus_cmd != 2'b00) begin
        if (prev_cmd == 2'b00) req_cnt++;
        cmd_s = o_dbus_cmd; addr_s = o_dbus_addr; ben_s = o_dbus_ben; wdata_s = o_dbus_wdata;
        if (req_n == wait_n) begin
          i_dbus_rdy = 1'b1; i_dbus_rdata = rdata; i_dbus_err = err;
          if (hold_stall) i_fetch_stall = 1'b1;
          done = 1;
        end
        req_n++;
      end else if (req_n == 0) begin
        // a bus ready outside REQ must be ignored
        i_dbus_rdy = 1'b1; i_dbus_rdata = 32'hBAD0BAD0;
      end
      prev_cmd = o_dbus_cmd;
      #1;
      if (o_mem_stall) stall_cnt++;
      @(posedge clk); #1;
      i_dbus_rdy = 1'b0; i_dbus_err = 1'b0; i_dbus_rdata = 32'hDEADDEAD;
      cyc++;
    end
    checks++;
    if (!done) begin
      failures++;
      $display("FAIL bus_timeout got=no_request_completed exp=completion");
    end
    if (!hold_stall) begin
      i_lsu_op = 2'b00; i_rd_no = 5'd0; i_alu_result = 32'h0;
    end
  endtask

  task automatic test_reset();
    nrst = 1'b0;
    repeat (2) @(negedge clk);
    checks++; if (o_rd_no !== 5'd0) begin failures++; $display("FAIL reset_rd_no got=%0h exp=0", o_rd_no); end
    checks++; if (o_rd_val !== 32'h0) begin failures++; $display("FAIL reset_rd_val got=%0h exp=0", o_rd_val); end
    checks++; if (o_bus_error !== 1'b0) begin failures++; $display("FAIL reset_bus_error got=%0b exp=0", o_bus_error); end
    checks++; if (o_dbus_cmd !== 2'b00) begin failures++; $display("FAIL reset_cmd got=%0b exp=00", o_dbus_cmd); end
    checks++; if (o_dbus_addr !== 32'h0) begin failures++; $display("FAIL reset_addr got=%0h exp=0", o_dbus_addr); end
    checks++; if (o_dbus_ben !== 4'h0) begin failures++; $display("FAIL reset_ben got=%0b exp=0000", o_dbus_ben); end
    checks++; if (o_dbus_wdata !== 32'h0) begin failures++; $display("FAIL reset_wdata got=%0h exp=0", o_dbus_wdata); end
    checks++; if (o_mem_stall !== 1'b0) begin failures++; $display("FAIL reset_mem_stall got=%0b exp=0", o_mem_stall); end
    @(posedge clk); #1;
    nrst = 1'b1;
    @(negedge clk);
    checks++; if (o_dbus_cmd !== 2'b00 || o_mem_stall !== 1'b0) begin
      failures++; $display("FAIL idle_after_reset got=cmd%0b/stall%0b exp=cmd00/stall0", o_dbus_cmd, o_mem_stall);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_passthrough();
    exp_t e;
    i_lsu_op = 2'b00; i_rd_no = 5'd7; i_alu_result = 32'hDEADBEEF;
    sb_q.push_back('{rd: 5'd7, val: 32'hDEADBEEF});
    @(negedge clk);
    checks++; if (o_mem_stall !== 1'b0) begin failures++; $display("FAIL alu_no_stall got=%0b exp=0", o_mem_stall); end
    @(posedge clk); #1;
    e = sb_q.pop_front();
    checks++; if (o_rd_no !== e.rd || o_rd_val !== e.val) begin
      failures++; $display("FAIL alu_pass got=%0d/%h exp=%0d/%h", o_rd_no, o_rd_val, e.rd, e.val);
    end
    i_rd_no = 5'd9; i_alu_result = 32'h12345678; i_nullify = 1'b1;
    sb_q.push_back('{rd: 5'd0, val: 32'h12345678});
    @(posedge clk); #1;
    e = sb_q.pop_front();
    checks++; if (o_rd_no !== e.rd) begin
      failures++; $display("FAIL alu_nullify got=%0d exp=%0d", o_rd_no, e.rd);
    end
    i_nullify = 1'b0; i_rd_no = 5'd0; i_alu_result = 32'h0;
  endtask

  task automatic test_load_byte();
    exp_t e; int st; logic [1:0] c; logic [31:0] a; logic [3:0] b; logic [31:0] w; int n;
    for (int k = 0; k < 2; k++) begin
      i_rd_no = 5'd5; i_alu_result = 32'h0000_1003; i_lsu_op = 2'b01;
      i_lsu_lns = 1'b0; i_lsu_ext = (k == 0);
      sb_q.push_back('{rd: 5'd5, val: (k == 0) ? 32'hFFFF_FF80 : 32'h0000_0080});
      run_mem(32'h8011_2233, 2, 1'b0, 1'b0, st, c, a, b, w, n);
      checks++; if (c !== 2'b01 || a !== 32'h0000_1000 || b !== 4'b1000) begin
        failures++; $display("FAIL lb_bus got=%0b/%h/%b exp=01/00001000/1000", c, a, b);
      end
      checks++; if (st != 3 || n != 1) begin
        failures++; $display("FAIL lb_stall got=stall%0d/req%0d exp=stall3/req1", st, n);
      end
      e = sb_q.pop_front();
      checks++; if (o_rd_no !== e.rd || o_rd_val !== e.val) begin
        failures++; $display("FAIL lb_result ext=%0d got=%0d/%h exp=%0d/%h", 1 - k, o_rd_no, o_rd_val, e.rd, e.val);
      end
    end
  endtask

  task automatic test_store_half();
    exp_t e; int st; logic [1:0] c; logic [31:0] a; logic [3:0] b; logic [31:0] w; int n;
    i_rd_no = 5'd6; i_alu_result = 32'h0000_2002; i_lsu_op = 2'b10;
    i_lsu_lns = 1'b1; i_lsu_ext = 1'b0; i_mem_data = 32'h1234_ABCD;
    sb_q.push_back('{rd: 5'd0, val: 32'h0});
    run_mem(32'h0, 1, 1'b0, 1'b0, st, c, a, b, w, n);
    checks++; if (c !== 2'b10 || a !== 32'h0000_2000 || b !== 4'b1100 || w !== 32'hABCD_ABCD) begin
      failures++; $display("FAIL sh_bus got=%0b/%h/%b/%h exp=10/00002000/1100/abcdabcd", c, a, b, w);
    end
    e = sb_q.pop_front();
    checks++; if (o_rd_no !== e.rd) begin failures++; $display("FAIL sh_rd got=%0d exp=%0d", o_rd_no, e.rd); end
    i_lsu_lns = 1'b0;
  endtask

  task automatic test_misaligned();
    i_rd_no = 5'd3; i_alu_result = 32'h55; i_lsu_op = 2'b00;
    @(posedge clk); #1;
    i_rd_no = 5'd8; i_alu_result = 32'h0000_3001; i_lsu_op = 2'b11; i_lsu_lns = 1'b0;
    @(negedge clk);
    checks++; if (o_addr_error !== 1'b1 || o_dbus_cmd !== 2'b00 || o_mem_stall !== 1'b0) begin
      failures++; $display("FAIL mis_word got=aerr%0b/cmd%0b/stall%0b exp=1/00/0", o_addr_error, o_dbus_cmd, o_mem_stall);
    end
    @(posedge clk); #1;
    checks++; if (o_rd_no !== 5'd0 || o_dbus_cmd !== 2'b00) begin
      failures++; $display("FAIL mis_rd got=%0d/cmd%0b exp=0/00", o_rd_no, o_dbus_cmd);
    end
    i_alu_result = 32'h0000_3003; i_lsu_op = 2'b10;
    @(negedge clk);
    checks++; if (o_addr_error !== 1'b1 || o_mem_stall !== 1'b0) begin
      failures++; $display("FAIL mis_half got=aerr%0b/stall%0b exp=1/0", o_addr_error, o_mem_stall);
    end
    @(posedge clk); #1;
    i_lsu_op = 2'b00; i_rd_no = 5'd0; i_alu_result = 32'h0;
    @(posedge clk); #1;
  endtask

  task automatic test_done_stall();
    exp_t e; int st; logic [1:0] c; logic [31:0] a; logic [3:0] b; logic [31:0] w; int n;
    int reissue;
    i_rd_no = 5'd12; i_alu_result = 32'h0000_4004; i_lsu_op = 2'b11; i_lsu_ext = 1'b0;
    sb_q.push_back('{rd: 5'd12, val: 32'hCAFE_F00D});
    run_mem(32'hCAFE_F00D, 1, 1'b0, 1'b1, st, c, a, b, w, n);
    e = sb_q.pop_front();
    checks++; if (o_rd_no !== e.rd || o_rd_val !== e.val) begin
      failures++; $display("FAIL done_result got=%0d/%h exp=%0d/%h", o_rd_no, o_rd_val, e.rd, e.val);
    end
    reissue = 0;
    repeat (2) begin
      @(negedge clk);
      if (o_dbus_cmd !== 2'b00) reissue++;
      checks++; if (o_mem_stall !== 1'b0 || o_rd_val !== 32'hCAFE_F00D) begin
        failures++; $display("FAIL done_hold got=stall%0b/%h exp=0/cafef00d", o_mem_stall, o_rd_val);
      end
      @(posedge clk); #1;
    end
    i_fetch_stall = 1'b0;
    @(negedge clk);
    if (o_dbus_cmd !== 2'b00) reissue++;
    checks++; if (o_mem_stall !== 1'b0) begin
      failures++; $display("FAIL done_release got=%0b exp=0", o_mem_stall);
    end
    @(posedge clk); #1;
    i_lsu_op = 2'b00; i_rd_no = 5'd0; i_alu_result = 32'h0;
    repeat (3) begin
      @(negedge clk);
      if (o_dbus_cmd !== 2'b00) reissue++;
      @(posedge clk); #1;
    end
    checks++; if (n != 1 || reissue != 0) begin
      failures++; $display("FAIL done_single_read got=req%0d/reissue%0d exp=1/0", n, reissue);
    end
  endtask

  task automatic test_bus_error();
    exp_t e; int st; logic [1:0] c; logic [31:0] a; logic [3:0] b; logic [31:0] w; int n;
    i_rd_no = 5'd4; i_alu_result = 32'h0000_5000; i_lsu_op = 2'b11;
    sb_q.push_back('{rd: 5'd0, val: 32'h0});
    run_mem(32'h1111_1111, 0, 1'b1, 1'b0, st, c, a, b, w, n);
    e = sb_q.pop_front();
    checks++; if (o_bus_error !== 1'b1 || o_rd_no !== e.rd) begin
      failures++; $display("FAIL berr_pulse got=berr%0b/rd%0d exp=1/%0d", o_bus_error, o_rd_no, e.rd);
    end
    checks++; if (b !== 4'b1111 || a !== 32'h0000_5000) begin
      failures++; $display("FAIL berr_bus got=%b/%h exp=1111/00005000", b, a);
    end
    @(posedge clk); #1;
    checks++; if (o_bus_error !== 1'b0) begin failures++; $display("FAIL berr_one_cycle got=%0b exp=0", o_bus_error); end
  endtask

  task automatic test_back_to_back();
    exp_t e; int st; logic [1:0] c; logic [31:0] a; logic [3:0] b; logic [31:0] w; int n;
    sb_q.push_back('{rd: 5'd10, val: 32'h0000_00B3});
    sb_q.push_back('{rd: 5'd11, val: 32'hFFFF_9ABC});
    i_rd_no = 5'd10; i_alu_result = 32'h0000_7001; i_lsu_op = 2'b01; i_lsu_ext = 1'b0;
    run_mem(32'h11A2_B3C4, 1, 1'b0, 1'b0, st, c, a, b, w, n);
    e = sb_q.pop_front();
    checks++; if (o_rd_no !== e.rd || o_rd_val !== e.val || b !== 4'b0010) begin
      failures++; $display("FAIL b2b_first got=%0d/%h/%b exp=%0d/%h/0010", o_rd_no, o_rd_val, b, e.rd, e.val);
    end
    i_rd_no = 5'd11; i_alu_result = 32'h0000_7002; i_lsu_op = 2'b10; i_lsu_ext = 1'b1;
    run_mem(32'h9ABC_0000, 0, 1'b0, 1'b0, st, c, a, b, w, n);
    e = sb_q.pop_front();
    checks++; if (o_rd_no !== e.rd || o_rd_val !== e.val || b !== 4'b1100 || st != 1) begin
      failures++; $display("FAIL b2b_second got=%0d/%h/%b/stall%0d exp=%0d/%h/1100/1", o_rd_no, o_rd_val, b, st, e.rd, e.val);
    end
    i_lsu_ext = 1'b0;
  endtask

  task automatic test_reset_mid_req();
    bit seen;
    seen = 0;
    i_rd_no = 5'd2; i_alu_result = 32'h0000_6008; i_lsu_op = 2'b11;
    for (int k = 0; k < 10 && !seen; k++) begin
      @(negedge clk);
      if (o_dbus_cmd == 2'b01) seen = 1;
      else begin @(posedge clk); #1; end
    end
    checks++; if (!seen) begin failures++; $display("FAIL rst_req_issue got=no_read exp=read"); end
    nrst = 1'b0; i_lsu_op = 2'b00; i_rd_no = 5'd0;
    #1;
    checks++; if (o_dbus_cmd !== 2'b00 || o_mem_stall !== 1'b0) begin
      failures++; $display("FAIL rst_mid_req got=cmd%0b/stall%0b exp=00/0", o_dbus_cmd, o_mem_stall);
    end
    @(posedge clk); #1;
    nrst = 1'b1;
    @(negedge clk);
    checks++; if (o_dbus_cmd !== 2'b00) begin failures++; $display("FAIL rst_after got=%0b exp=00", o_dbus_cmd); end
    @(posedge clk); #1;
  endtask

  initial begin
    nrst = 1'b0;
    i_exec_stall = 1'b0; i_fetch_stall = 1'b0; i_wait_stall = 1'b0; i_nullify = 1'b0;
    i_rd_no = 5'd0; i_alu_result = 32'h0; i_lsu_op = 2'b00; i_lsu_lns = 1'b0;
    i_lsu_ext = 1'b0; i_mem_data = 32'h0; i_dbus_rdata = 32'h0; i_dbus_rdy = 1'b0; i_dbus_err = 1'b0;
    test_reset();
    test_passthrough();
    test_load_byte();
    test_store_half();
    test_misaligned();
    test_done_stall();
    test_bus_error();
    test_back_to_back();
    test_reset_mid_req();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/uparc_memory_access.md
# uparc_memory_access

Memory access stage of the Ultiparc pipeline. It consumes the load/store command, address, store data and destination register issued by the execute stage, runs a single-outstanding transaction on the CPU data bus, and hands the aligned, extended result or pass-through ALU value to writeback. Data alignment faults are detected here, and the stage stalls the core while a transfer is in flight.

## Interface
- Parameters: none. Widths come from global config: address, data and register are 32 bits; register number is 5 bits; LSU op is 2 bits.
- clk  in  1  clock
- nrst  in  1  reset; asynchronous, active-low
- i_exec_stall, i_fetch_stall, i_wait_stall  in  1 each  stalls from other units
- i_nullify  in  1  kill the instruction currently at the stage inputs
- o_mem_stall  out  1  this stage stalls the core (combinational)
- o_addr_error  out  1  misaligned data access (combinational)
- o_bus_error  out  1  data bus error; one-cycle registered pulse
- i_rd_no  in  5  destination register
- i_alu_result  in  32  ALU result or effective address
- i_lsu_op  in  2  LSU op: 00 idle, 01 byte, 10 halfword, 11 word
- i_lsu_lns  in  1  0 load, 1 store
- i_lsu_ext  in  1  sign-extend loads
- i_mem_data  in  32  store data (rt)
- o_rd_no  out  5  writeback register; 0 means no write
- o_rd_val  out  32  writeback value
- o_dbus_addr  out  32  word address; bits [1:0] are always 0
- o_dbus_cmd  out  2  00 none, 01 read, 10 write
- o_dbus_ben  out  4  byte enables; bit n enables byte lane n
- o_dbus_wdata  out  32  write data
- i_dbus_rdata  in  32  read data
- i_dbus_rdy  in  1  transfer complete
- i_dbus_err  in  1  error; qualified by i_dbus_rdy

## Operation
- ostall = i_exec_stall | i_fetch_stall | i_wait_stall.
- Memory op = i_lsu_op != 00 and !i_nullify.
- Misaligned:
  - halfword with addr[0]=1
  - word with addr[1:0]!=0
- Bus endianness is little-endian; byte lane = addr[1:0].
- State machine:
  - IDLE -> REQ on an aligned memory op while !ostall.
  - REQ -> IDLE on i_dbus_rdy & !ostall.
  - REQ -> DONE on i_dbus_rdy & ostall.
  - DONE -> IDLE on !ostall.
- REQ state:
  - Request fields are captured on the IDLE->REQ edge and held stable until i_dbus_rdy.
  - o_dbus_cmd, o_dbus_addr, o_dbus_ben and o_dbus_wdata are driven from those captured registers.
  - In IDLE and DONE, o_dbus_cmd=00.
- DONE holds the result and prevents re-issue while the instruction is still presented at the inputs.
- o_mem_stall = (IDLE & aligned memory op) | (REQ & !i_dbus_rdy).
- Byte enables are 0001<<a (byte), 0011<<a (halfword), 1111 (word), for reads and writes alike. Here a=addr[1:0].
- Write data replicates rt: {4{rt[7:0]}} for byte, {2{rt[15:0]}} for halfword, rt for word.
- Load data:
  - Select rdata >> 8*addr[1:0], truncate to the access size.
  - If i_lsu_ext=1, sign-extend; otherwise zero-extend.
- Misaligned op in IDLE:
  - o_addr_error=1, no bus cycle, no self-stall.
  - At the next unstalled edge o_rd_no<=0.
- Writeback register update:
  - Non-memory op, IDLE, !ostall: o_rd_no<=i_rd_no (0 if i_nullify), o_rd_val<=i_alu_result.
  - Load completes without error: o_rd_no<=captured rd, o_rd_val<=extended data.
  - Store completes: o_rd_no<=0.
  - Completion with i_dbus_err: o_rd_no<=0, o_bus_error=1 for one cycle.
  - i_nullify high at the completion edge: o_rd_no<=0. The bus transfer itself is never aborted.
  - IDLE->REQ edge: o_rd_no<=0 (bubble).
  - ostall high: outputs hold.

## Timing
- Reset values: state IDLE; o_rd_no=0, o_rd_val=0, o_bus_error=0, o_dbus_cmd=00, o_dbus_addr=0, o_dbus_ben=0, o_dbus_wdata=0.
- Non-memory op: 1-cycle latency to o_rd_*.
- Memory op presented in cycle N:
  - Stall is asserted in N.
  - The command is on the bus from N+1.
  - With rdy in N+1+w, the result is valid in N+2+w; the core is stalled 1+w cycles.
- At most one outstanding transaction; no new request while in REQ or DONE.
- Reset during REQ: the stage returns to IDLE immediately and the command drops to 00. The interconnect must tolerate the abandoned request.
- i_dbus_rdy in IDLE or DONE is ignored.

## Test plan
- Reset, then idle: all outputs at reset values; o_mem_stall=0; o_dbus_cmd=00.
- Signed byte load: addr 0x1003, ext=1, rd=5, rdata 0x80112233, rdy after 2 wait cycles.
  - Bus: cmd 01, addr 0x1000, ben 1000.
  - o_mem_stall high 3 cycles.
  - Result: o_rd_no=5, o_rd_val=0xFFFFFF80.
  - With ext=0: o_rd_val=0x00000080.
- Halfword store: addr 0x2002, rt 0x1234ABCD.
  - Bus: cmd 10, addr 0x2000, ben 1100, wdata 0xABCDABCD.
  - After completion: o_rd_no=0.
- Misaligned word load: addr 0x3001.
  - o_addr_error=1, o_dbus_cmd stays 00, o_mem_stall=0.
  - Next cycle: o_rd_no=0.
- Load completing while i_fetch_stall=1 for 3 cycles: FSM enters DONE; exactly one bus read; o_rd_val holds; IDLE once the stall clears, with no re-issue.
- Bus error and reset:
  - Word load with rdy&err: o_bus_error pulses 1 cycle, o_rd_no=0.
  - nrst asserted mid-REQ: o_dbus_cmd=00 at once and state is IDLE.
